fetch_dual: RTL and testbench
=============================

Name: fetch_dual

Overview:
Dual-issue instruction-fetch control stage. It sits directly upstream of the IF/ID pipeline register and owns the program counter. It drives both instruction-memory read addresses and produces the PC_4/PC_8 link values consumed by IF/ID. It also generates the IF/ID flush for redirects, halt and reset, runs a RUN/HALT state machine, and counts accepted instruction pairs.

Parameters:
PC_W, 4, program-counter width in words; instruction memory is 2^PC_W words.
RESET_PC, 0, PC value loaded on reset.
HALT_OP, 6'b111111, opcode that halts fetch.
CNT_W, 16, width of the accepted-pair counter.

Ports:
reloj  in  1  clock; all state changes on the rising edge.
reset_n  in  1  reset, asynchronous, active-low.
stall  in  1  hazard-unit hold request; the PC is held.
redirect  in  1  taken jump/branch resolved in ID.
redirect_pc  in  PC_W  word target for redirect.
DO1  in  32  instruction-memory data, slot 1 (combinational read of addr1).
DO2  in  32  instruction-memory data, slot 2 (combinational read of addr2).
addr1  out  PC_W  instruction-memory address, slot 1 = PC.
addr2  out  PC_W  instruction-memory address, slot 2 = PC+1.
PC_4  out  PC_W  PC+1, to IF/ID.
PC_8  out  PC_W  PC+2, to IF/ID.
flush_if  out  1  drives the IF/ID resetIF input.
halted  out  1  high while the state machine is in HALT.
pair_count  out  CNT_W  number of accepted instruction pairs.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - PC=RESET_PC, state=RUN, pair_count=0.
  - halted=0.
  - flush_if=1 for as long as reset_n=0, so IF/ID clears on every edge during reset.
- Combinational outputs:
  - addr1=PC; addr2=PC+1; PC_4=PC+1; PC_8=PC+2.
  - All PC arithmetic is mod 2^PC_W.
  - flush_if = !reset_n | (state==RUN & redirect) | (state==HALT).
  - halted = (state==HALT).
- RUN state, priority order:
  1. redirect: next PC=redirect_pc; flush_if=1 this cycle; no halt detection; pair_count is not incremented (the pair is wrong-path). redirect wins over a simultaneous stall.
  2. stall: PC holds, flush_if=0, no halt detection, pair_count unchanged. IF/ID reloads the same DO/PC values, which is an effective hold.
  3. HALT_OP in DO1[31:26] or DO2[31:26]: state goes to HALT; PC holds; pair_count increments (the halt pair is accepted into IF/ID).
  4. Otherwise: PC=PC+2; pair_count increments.
- HALT state:
  - PC frozen; flush_if=1 every cycle, so IF/ID feeds NOPs.
  - redirect and stall are ignored; pair_count is frozen.
  - Exit only through reset_n.
- Latency:
  - A redirect asserted in cycle N makes addr1=redirect_pc in cycle N+1.
  - The halt pair fetched in cycle N is latched by IF/ID at the end of N; halted=1 and flush_if=1 from cycle N+1.
- Halt in slot 1: this block does not squash slot 2. Toolchain rule: HALT sits in slot 2, or slot 2 holds a NOP.
- Wrap-around: at PC=2^PC_W-1, addr2=0, PC_8=1, next PC=1. An odd redirect target is legal; pairs are then odd-aligned.
- pair_count saturates at all-ones and does not wrap.
- Reset mid-operation (any state): immediate return to reset values; no pending redirect or halt survives.

Decomposition:
- Shared pipeline package holds:
  - PC_W and HALT_OP, so decode uses the same values;
  - the state encoding (RUN=1'b0, HALT=1'b1);
  - the opcode field slice [31:26].
- One sub-module is natural: sat_counter (parameterised width, increment enable, async active-low clear). It is reused later by the performance counters.
- PC register, next-PC mux and FSM stay in fetch_dual.

Test Plan:
1. Reset, then release with no stall or redirect for 3 cycles -> addr1 = 0,2,4; addr2 = 1,3,5; PC_4 = 1,3,5; PC_8 = 2,4,6; pair_count = 3; flush_if = 0 after release.
2. redirect=1, redirect_pc=15 -> flush_if=1 that cycle. Next cycle: addr1=15, addr2=0, PC_4=0, PC_8=1. Following cycle: addr1=1.
3. At PC=4, stall=1 for 2 cycles -> addr1 stays 4 and pair_count is unchanged for both cycles; flush_if=0. Then addr1=6.
4. At PC=6, stall=1 and redirect=1 with redirect_pc=3 in the same cycle -> flush_if=1, pair_count unchanged, next addr1=3.
5. At PC=8, DO2 opcode=HALT_OP -> next cycle: halted=1, flush_if=1, addr1 stays 8, pair_count incremented once. Then 5 cycles with redirect=1 and redirect_pc=0 -> addr1 stays 8 and pair_count is frozen.
6. In HALT, pulse reset_n low between clock edges -> halted=0, addr1=RESET_PC and pair_count=0 immediately; flush_if=1 while low. After release, addr1 advances 0,2.

Source files
------------

// File: rtl/fetch_dual_pkg.sv
// Shared pipeline definitions for fetch and decode: PC width, halt opcode,
// fetch state encoding and the opcode field helpers.
package fetch_dual_pkg;

    localparam int FETCH_PC_W = 4;
    localparam int OPC_HI     = 31;
    localparam int OPC_LO     = 26;
    localparam int OPC_W      = OPC_HI - OPC_LO + 1;

    localparam logic [OPC_W-1:0] FETCH_HALT_OP = 6'b111111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [31:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

    function automatic logic is_halt_op(input logic [31:0] instr,
                                        input logic [OPC_W-1:0] halt_op);
        return (opcode_of(instr) == halt_op);
    endfunction

endpackage

// File: rtl/fetch_dual_sat_counter.sv
// Saturating up-counter with async active-low clear and synchronous soft clear;
// shared with the performance counters.
module sat_counter
    import fetch_dual_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         srst_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: soft clear wins, then increment that sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (srst_i) begin
            cnt_d = CNT_ZERO;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_dual.sv
// Dual-issue fetch control: owns the PC, drives both instruction-memory
// addresses, generates the IF/ID flush and runs the RUN/HALT machine.
module fetch_dual
    import fetch_dual_pkg::*;
#(
    parameter int               PC_W     = FETCH_PC_W,
    parameter logic [PC_W-1:0]  RESET_PC = {PC_W{1'b0}},
    parameter logic [OPC_W-1:0] HALT_OP  = FETCH_HALT_OP,
    parameter int               CNT_W    = 16
) (
    input  logic              reloj,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic [31:0]       DO1,
    input  logic [31:0]       DO2,
    output logic [PC_W-1:0]   addr1,
    output logic [PC_W-1:0]   addr2,
    output logic [PC_W-1:0]   PC_4,
    output logic [PC_W-1:0]   PC_8,
    output logic              flush_if,
    output logic              halted,
    output logic [CNT_W-1:0]  pair_count
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0] PC_TWO = PC_ONE + PC_ONE;

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            cnt_en_s;
    logic            flush_s;
    logic            halt_seen_s;

    assign halt_seen_s = is_halt_op(DO1, HALT_OP) | is_halt_op(DO2, HALT_OP);

    // Next-state, next-PC and flush; redirect outranks stall, stall outranks halt.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_en_s = 1'b0;
        flush_s  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    flush_s = 1'b1;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (halt_seen_s) begin
                    state_d  = ST_HALT;
                    cnt_en_s = 1'b1;
                end else begin
                    pc_d     = pc_q + PC_TWO;
                    cnt_en_s = 1'b1;
                end
            end
            ST_HALT: begin
                flush_s = 1'b1;
            end
            default: begin
                state_d = ST_HALT;
                flush_s = 1'b1;
            end
        endcase
    end

    // PC and state registers; only reset leaves HALT.
    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_pair_cnt (
        .clk_i   (reloj),
        .rst_ni  (reset_n),
        .srst_i  (1'b0),
        .en_i    (cnt_en_s),
        .count_o (pair_count)
    );

    // Reset forces the flush so IF/ID clears on every edge while held low.
    assign flush_if = !reset_n | flush_s;
    assign halted   = (state_q == ST_HALT);
    assign addr1    = pc_q;
    assign addr2    = pc_q + PC_ONE;
    assign PC_4     = pc_q + PC_ONE;
    assign PC_8     = pc_q + PC_TWO;

endmodule

// File: tb/tb_fetch_dual.sv
// Self-checking bench for fetch_dual: directed scenarios plus randomized
// traffic checked against a behavioural PC/halt/count model.
module tb_fetch_dual;

    localparam int PW      = 4;
    localparam int CW      = 4;
    localparam int PC_MOD  = 16;
    localparam int CNT_MAX = 15;

    logic          reloj = 1'b0;
    logic          reset_n;
    logic          stall;
    logic          redirect;
    logic [PW-1:0] redirect_pc;
    logic [31:0]   DO1;
    logic [31:0]   DO2;
    logic [PW-1:0] addr1;
    logic [PW-1:0] addr2;
    logic [PW-1:0] PC_4;
    logic [PW-1:0] PC_8;
    logic          flush_if;
    logic          halted;
    logic [CW-1:0] pair_count;

    int total = 0;
    int bad   = 0;
    int m_pc;
    int m_cnt;
    bit m_halt;

    fetch_dual #(
        .PC_W     (PW),
        .RESET_PC (4'd0),
        .HALT_OP  (6'b111111),
        .CNT_W    (CW)
    ) dut (
        .reloj       (reloj),
        .reset_n     (reset_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .DO1         (DO1),
        .DO2         (DO2),
        .addr1       (addr1),
        .addr2       (addr2),
        .PC_4        (PC_4),
        .PC_8        (PC_8),
        .flush_if    (flush_if),
        .halted      (halted),
        .pair_count  (pair_count)
    );

    always #5 reloj = ~reloj;

    function automatic logic [31:0] word(input bit halt);
        logic [5:0] op;
        op = halt ? 6'b111111 : 6'($urandom_range(0, 62));
        return {op, 26'($urandom)};
    endfunction

    task automatic model_reset();
        m_pc   = 0;
        m_cnt  = 0;
        m_halt = 1'b0;
    endtask

    task automatic drive(input logic st, input logic rd, input logic [PW-1:0] rpc,
                         input logic [31:0] d1, input logic [31:0] d2);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        DO1         = d1;
        DO2         = d2;
        #1;
    endtask

    // One rising edge: the model applies the fetch rules to the inputs in force.
    task automatic tick();
        bit hop;
        @(posedge reloj);
        hop = (DO1[31:26] == 6'b111111) || (DO2[31:26] == 6'b111111);
        if (!m_halt) begin
            if (redirect) begin
                m_pc = int'(redirect_pc);
            end else if (!stall) begin
                if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
                if (hop) m_halt = 1'b1;
                else     m_pc   = (m_pc + 2) % PC_MOD;
            end
        end
        @(negedge reloj);
    endtask

    task automatic hard_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 4'd0, word(1'b0), word(1'b0));
        model_reset();
        repeat (2) @(negedge reloj);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic step_normal();
        drive(1'b0, 1'b0, 4'd0, word(1'b0), word(1'b0));
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 4'd0, word(1'b0), word(1'b0));
        model_reset();
        if (halted !== 1'b0) begin $display("FAIL reset_halted got=%0d exp=0", halted); bad++; end
        total++;
        if (flush_if !== 1'b1) begin $display("FAIL reset_flush got=%0d exp=1", flush_if); bad++; end
        total++;
        if (addr1 !== 4'd0) begin $display("FAIL reset_addr1 got=%0d exp=0", addr1); bad++; end
        total++;
        if (pair_count !== 4'd0) begin $display("FAIL reset_count got=%0d exp=0", pair_count); bad++; end
        total++;
        @(posedge reloj);
        #1;
        if (flush_if !== 1'b1 || addr1 !== 4'd0) begin
            $display("FAIL reset_hold flush=%0d addr1=%0d exp 1/0", flush_if, addr1); bad++;
        end
        total++;
        @(negedge reloj);
        reset_n = 1'b1;
        #1;
        if (flush_if !== 1'b0) begin $display("FAIL reset_release_flush got=%0d exp=0", flush_if); bad++; end
        total++;
    endtask

    task automatic test_sequential();
        hard_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 4'd0, word(1'b0), word(1'b0));
            if (addr1 !== 4'(2*i) || addr2 !== 4'(2*i+1) || PC_4 !== 4'(2*i+1) || PC_8 !== 4'(2*i+2)) begin
                $display("FAIL seq_addr cyc=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", i,
                         addr1, addr2, PC_4, PC_8, 2*i, 2*i+1, 2*i+1, 2*i+2);
                bad++;
            end
            total++;
            if (flush_if !== 1'b0) begin $display("FAIL seq_flush got=%0d exp=0", flush_if); bad++; end
            total++;
            tick();
        end
        if (pair_count !== 4'd3) begin $display("FAIL seq_count got=%0d exp=3", pair_count); bad++; end
        total++;
    endtask

    task automatic test_redirect();
        hard_reset();
        drive(1'b0, 1'b1, 4'd15, word(1'b0), word(1'b0));
        if (flush_if !== 1'b1) begin $display("FAIL redir_flush got=%0d exp=1", flush_if); bad++; end
        total++;
        tick();
        drive(1'b0, 1'b0, 4'd0, word(1'b0), word(1'b0));
        if (addr1 !== 4'd15 || addr2 !== 4'd0 || PC_4 !== 4'd0 || PC_8 !== 4'd1) begin
            $display("FAIL redir_wrap got=%0d/%0d/%0d/%0d exp=15/0/0/1", addr1, addr2, PC_4, PC_8);
            bad++;
        end
        total++;
        if (pair_count !== 4'd0) begin $display("FAIL redir_count got=%0d exp=0", pair_count); bad++; end
        total++;
        tick();
        if (addr1 !== 4'd1) begin $display("FAIL redir_next got=%0d exp=1", addr1); bad++; end
        total++;
    endtask

    task automatic test_stall();
        hard_reset();
        repeat (2) step_normal();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 4'd0, word(1'b0), word(1'b1));
            if (addr1 !== 4'd4 || pair_count !== 4'd2 || flush_if !== 1'b0) begin
                $display("FAIL stall_hold cyc=%0d got=%0d/%0d/%0d exp=4/2/0", i, addr1, pair_count, flush_if);
                bad++;
            end
            total++;
            tick();
        end
        drive(1'b0, 1'b0, 4'd0, word(1'b0), word(1'b0));
        if (addr1 !== 4'd4 || pair_count !== 4'd2) begin
            $display("FAIL stall_after got=%0d/%0d exp=4/2", addr1, pair_count); bad++;
        end
        total++;
        tick();
        if (addr1 !== 4'd6) begin $display("FAIL stall_resume got=%0d exp=6", addr1); bad++; end
        total++;
    endtask

    task automatic test_stall_redirect();
        hard_reset();
        repeat (3) step_normal();
        drive(1'b1, 1'b1, 4'd3, word(1'b0), word(1'b0));
        if (addr1 !== 4'd6 || flush_if !== 1'b1) begin
            $display("FAIL sr_flush got=%0d/%0d exp=6/1", addr1, flush_if); bad++;
        end
        total++;
        tick();
        if (addr1 !== 4'd3 || pair_count !== 4'd3) begin
            $display("FAIL sr_target got=%0d/%0d exp=3/3", addr1, pair_count); bad++;
        end
        total++;
    endtask

    task automatic test_halt();
        hard_reset();
        repeat (4) step_normal();
        drive(1'b0, 1'b0, 4'd0, word(1'b0), word(1'b1));
        if (addr1 !== 4'd8 || halted !== 1'b0 || flush_if !== 1'b0) begin
            $display("FAIL halt_pre got=%0d/%0d/%0d exp=8/0/0", addr1, halted, flush_if); bad++;
        end
        total++;
        tick();
        if (halted !== 1'b1 || flush_if !== 1'b1 || addr1 !== 4'd8 || pair_count !== 4'd5) begin
            $display("FAIL halt_enter got=%0d/%0d/%0d/%0d exp=1/1/8/5", halted, flush_if, addr1, pair_count);
            bad++;
        end
        total++;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 4'd0, word(1'b0), word(1'b0));
            tick();
            if (addr1 !== 4'd8 || pair_count !== 4'd5 || flush_if !== 1'b1 || halted !== 1'b1) begin
                $display("FAIL halt_frozen cyc=%0d got=%0d/%0d/%0d/%0d exp=8/5/1/1", i,
                         addr1, pair_count, flush_if, halted);
                bad++;
            end
            total++;
        end
    endtask

    task automatic test_reset_in_halt();
        reset_n = 1'b0;
        #1;
        model_reset();
        if (halted !== 1'b0 || addr1 !== 4'd0 || pair_count !== 4'd0 || flush_if !== 1'b1) begin
            $display("FAIL rst_halt got=%0d/%0d/%0d/%0d exp=0/0/0/1", halted, addr1, pair_count, flush_if);
            bad++;
        end
        total++;
        #1;
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 4'd0, word(1'b0), word(1'b0));
        if (addr1 !== 4'd0 || flush_if !== 1'b0) begin
            $display("FAIL rst_halt_rel got=%0d/%0d exp=0/0", addr1, flush_if); bad++;
        end
        total++;
        tick();
        if (addr1 !== 4'd2) begin $display("FAIL rst_halt_adv got=%0d exp=2", addr1); bad++; end
        total++;
    endtask

    task automatic test_saturate();
        hard_reset();
        repeat (CNT_MAX) step_normal();
        if (pair_count !== 4'd15) begin $display("FAIL sat_reach got=%0d exp=15", pair_count); bad++; end
        total++;
        repeat (5) step_normal();
        if (pair_count !== 4'd15) begin $display("FAIL sat_hold got=%0d exp=15", pair_count); bad++; end
        total++;
    endtask

    task automatic test_random();
        logic st;
        logic rd;
        hard_reset();
        for (int i = 0; i < 300; i++) begin
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 4) == 0);
            drive(st, rd, 4'($urandom), word($urandom_range(0, 19) == 0), word($urandom_range(0, 11) == 0));
            if (addr1 !== 4'(m_pc) || addr2 !== 4'((m_pc + 1) % PC_MOD) ||
                PC_4 !== 4'((m_pc + 1) % PC_MOD) || PC_8 !== 4'((m_pc + 2) % PC_MOD)) begin
                $display("FAIL rnd_addr cyc=%0d got=%0d/%0d/%0d/%0d exp_pc=%0d", i,
                         addr1, addr2, PC_4, PC_8, m_pc);
                bad++;
            end
            total++;
            if (halted !== m_halt || flush_if !== (m_halt || rd)) begin
                $display("FAIL rnd_ctrl cyc=%0d got=%0d/%0d exp=%0d/%0d", i, halted, flush_if,
                         m_halt, (m_halt || rd));
                bad++;
            end
            total++;
            if (pair_count !== 4'(m_cnt)) begin
                $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, pair_count, m_cnt); bad++;
            end
            total++;
            tick();
            if (m_halt && $urandom_range(0, 5) == 0) begin
                reset_n = 1'b0;
                #1;
                model_reset();
                if (addr1 !== 4'd0 || flush_if !== 1'b1 || halted !== 1'b0) begin
                    $display("FAIL rnd_reset got=%0d/%0d/%0d exp=0/1/0", addr1, flush_if, halted); bad++;
                end
                total++;
                reset_n = 1'b1;
            end
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 4'd0;
        DO1         = 32'd0;
        DO2         = 32'd0;
        @(negedge reloj);
        test_reset();
        test_sequential();
        test_redirect();
        test_stall();
        test_stall_redirect();
        test_halt();
        test_reset_in_halt();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
